// File: rtl/tdc_frame_gen.sv
// tdc_frame_gen
// Multiphase DLL phase ring plus programmable, optionally bursted TDC start
// pulse train. The ring free-runs from reset; the frame FSM (IDLE/RUN/DONE)
// is armed by a rising edge of en and frames each measurement with start_o.
// Configuration is captured into shadow registers at arm time so that
// changes during a burst do not disturb frame spacing.

module tdc_frame_gen #(
    parameter int NPHASE = 32,
    parameter int NHIGH  = 16,
    parameter int CNT_W  = 20,
    parameter int SHOT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_offset,
    input  logic [7:0]        cfg_width,
    input  logic [SHOT_W-1:0] cfg_shots,
    output logic [NPHASE-1:0] phase_o,
    output logic              start_o,
    output logic [CNT_W-1:0]  frame_cnt_o,
    output logic [SHOT_W-1:0] shot_idx_o,
    output logic              busy_o,
    output logic              done_o
);

    // Top NHIGH taps set, remaining taps clear.
    localparam logic [NPHASE-1:0] RING_RST = ~({NPHASE{1'b1}} >> NHIGH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [NPHASE-1:0]   phase_r;
    logic                en_q_r;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [SHOT_W-1:0]   shot_r, shot_s;
    logic                start_r, start_s;
    logic [7:0]          wcnt_r, wcnt_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic [CNT_W-1:0]    period_sh_r, period_sh_s;
    logic [CNT_W-1:0]    offset_sh_r, offset_sh_s;
    logic [7:0]          width_sh_r, width_sh_s;
    logic [SHOT_W-1:0]   shots_sh_r, shots_sh_s;
    logic                arm_s;
    logic [CNT_W-1:0]    period_eff_s;
    logic [CNT_W-1:0]    offset_eff_s;
    logic [7:0]          width_eff_s;

    // Phase ring: rotate right every edge, reload pattern on reset.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            phase_r <= RING_RST;
        end else begin
            phase_r <= {phase_r[0], phase_r[NPHASE-1:1]};
        end
    end

    // Registered copy of en for rising-edge (arm) detection.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            en_q_r <= 1'b0;
        end else begin
            en_q_r <= en;
        end
    end

    // Clamp raw configuration: period >= 1, offset <= period, width >= 1.
    always_comb begin
        arm_s        = en & ~en_q_r;
        period_eff_s = cfg_period;
        offset_eff_s = cfg_offset;
        width_eff_s  = cfg_width;
        if (cfg_period == {CNT_W{1'b0}}) begin
            period_eff_s = CNT_W'(1);
        end else begin
            period_eff_s = cfg_period;
        end
        if (cfg_offset > period_eff_s) begin
            offset_eff_s = period_eff_s;
        end else begin
            offset_eff_s = cfg_offset;
        end
        if (cfg_width == 8'd0) begin
            width_eff_s = 8'd1;
        end else begin
            width_eff_s = cfg_width;
        end
    end

    // Frame FSM next-state and next-output logic.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        shot_s      = shot_r;
        start_s     = 1'b0;
        wcnt_s      = wcnt_r;
        period_sh_s = period_sh_r;
        offset_sh_s = offset_sh_r;
        width_sh_s  = width_sh_r;
        shots_sh_s  = shots_sh_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                if (arm_s) begin
                    period_sh_s = period_eff_s;
                    offset_sh_s = offset_eff_s;
                    width_sh_s  = width_eff_s;
                    shots_sh_s  = cfg_shots;
                    shot_s      = {SHOT_W{1'b0}};
                    state_s     = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    // Abort: shot index is kept for readout.
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end else if ((shots_sh_r != {SHOT_W{1'b0}}) &&
                             (cnt_r == period_sh_r) &&
                             (shot_r == shots_sh_r)) begin
                    state_s = ST_DONE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_RUN;
                    if (cnt_r == period_sh_r) begin
                        cnt_s = {CNT_W{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                    if (cnt_r == offset_sh_r) begin
                        start_s = 1'b1;
                        shot_s  = shot_r + SHOT_W'(1);
                        wcnt_s  = width_sh_r;
                    end else if (start_r) begin
                        if (cnt_r == period_sh_r) begin
                            // Pulse never crosses the frame boundary.
                            start_s = 1'b0;
                        end else if (wcnt_r <= 8'd1) begin
                            start_s = 1'b0;
                        end else begin
                            start_s = 1'b1;
                            wcnt_s  = wcnt_r - 8'd1;
                        end
                    end else begin
                        start_s = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
        busy_s = (state_s == ST_RUN);
        done_s = (state_s == ST_DONE);
    end

    // Frame FSM state, counters, shadows and registered outputs.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            shot_r      <= {SHOT_W{1'b0}};
            start_r     <= 1'b0;
            wcnt_r      <= 8'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            period_sh_r <= CNT_W'(1);
            offset_sh_r <= {CNT_W{1'b0}};
            width_sh_r  <= 8'd1;
            shots_sh_r  <= {SHOT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            shot_r      <= shot_s;
            start_r     <= start_s;
            wcnt_r      <= wcnt_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            period_sh_r <= period_sh_s;
            offset_sh_r <= offset_sh_s;
            width_sh_r  <= width_sh_s;
            shots_sh_r  <= shots_sh_s;
        end
    end

    assign phase_o     = phase_r;
    assign start_o     = start_r;
    assign frame_cnt_o = cnt_r;
    assign shot_idx_o  = shot_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;

endmodule

// File: tb/tb_tdc_frame_gen.sv
// Directed bench for tdc_frame_gen: reset/ring pattern, continuous frames,
// finite burst, truncation and clamps, config shadowing, abort, async reset.

module tb_tdc_frame_gen;

    logic        clk_i = 1'b0;
    logic        rst;
    logic        en;
    logic [19:0] cfg_period;
    logic [19:0] cfg_offset;
    logic [7:0]  cfg_width;
    logic [15:0] cfg_shots;
    logic [31:0] phase_o;
    logic        start_o;
    logic [19:0] frame_cnt_o;
    logic [15:0] shot_idx_o;
    logic        busy_o;
    logic        done_o;

    int n_vec  = 0;
    int n_miss = 0;

    tdc_frame_gen #(
        .NPHASE(32), .NHIGH(16), .CNT_W(20), .SHOT_W(16)
    ) dut (
        .clk_i(clk_i), .rst(rst), .en(en),
        .cfg_period(cfg_period), .cfg_offset(cfg_offset),
        .cfg_width(cfg_width), .cfg_shots(cfg_shots),
        .phase_o(phase_o), .start_o(start_o), .frame_cnt_o(frame_cnt_o),
        .shot_idx_o(shot_idx_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cfg(input int p, input int o, input int w, input int s);
        cfg_period = 20'(p);
        cfg_offset = 20'(o);
        cfg_width  = 8'(w);
        cfg_shots  = 16'(s);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_phase"}, 64'(phase_o), 64'hFFFF0000);
        check({tag, "_start"}, 64'(start_o), 64'd0);
        check({tag, "_cnt"},   64'(frame_cnt_o), 64'd0);
        check({tag, "_shot"},  64'(shot_idx_o), 64'd0);
        check({tag, "_busy"},  64'(busy_o), 64'd0);
        check({tag, "_done"},  64'(done_o), 64'd0);
    endtask

    // Arm: en rises before edge E0; returns just after E0.
    task automatic arm();
        en = 1'b1;
        tick();
        check("arm_busy", 64'(busy_o), 64'd1);
        check("arm_cnt",  64'(frame_cnt_o), 64'd0);
        check("arm_shot", 64'(shot_idx_o), 64'd0);
    endtask

    task automatic abort();
        en = 1'b0;
        tick();
        check("abort_busy",  64'(busy_o), 64'd0);
        check("abort_start", 64'(start_o), 64'd0);
        check("abort_done",  64'(done_o), 64'd0);
    endtask

    initial begin
        int ones;
        logic exp_s;
        rst = 1'b0;
        en  = 1'b0;
        set_cfg(0, 0, 0, 0);

        // Reset state and ring
        #23;
        check_reset_outputs("rst");
        @(negedge clk_i);
        rst = 1'b1;
        #1;
        check("ring_rel", 64'(phase_o), 64'hFFFF0000);
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            if (phase_o[0]) ones++;
            tick();
            if (i == 0) check("ring_e1", 64'(phase_o), 64'h7FFF8000);
        end
        check("ring_e32", 64'(phase_o), 64'hFFFF0000);
        check("ring_duty", 64'(ones), 64'd16);

        // Continuous frames: period 640, offset 10, width 1
        set_cfg(640, 10, 1, 0);
        arm();
        for (int k = 1; k <= 1300; k++) begin
            tick();
            exp_s = (k == 11) || (k == 652) || (k == 1293);
            check("cont_start", 64'(start_o), 64'(exp_s));
            if (exp_s) begin
                check("cont_shot", 64'(shot_idx_o), 64'((k + 630) / 641));
                check("cont_cnt",  64'(frame_cnt_o), 64'd11);
            end
        end
        abort();
        check("cont_shot_held", 64'(shot_idx_o), 64'd3);

        // Finite burst: period 99, offset 5, width 4, shots 3
        set_cfg(99, 5, 4, 3);
        arm();
        for (int k = 1; k <= 330; k++) begin
            tick();
            exp_s = (k < 300) && ((k % 100) >= 6) && ((k % 100) <= 9);
            check("burst_start", 64'(start_o), 64'(exp_s));
            check("burst_done",  64'(done_o), 64'(k == 300));
            check("burst_busy",  64'(busy_o), 64'(k < 300));
        end
        check("burst_shot", 64'(shot_idx_o), 64'd3);
        en = 1'b0;
        tick();

        // Truncation at frame boundary: period 20, offset 18, width 10
        set_cfg(20, 18, 10, 0);
        arm();
        for (int k = 1; k <= 42; k++) begin
            tick();
            check("trunc_start", 64'(start_o), 64'(((k % 21) == 19) || ((k % 21) == 20)));
        end
        abort();

        // Offset beyond period clamps to period
        set_cfg(20, 50, 1, 0);
        arm();
        for (int k = 1; k <= 42; k++) begin
            tick();
            check("clamp_start", 64'(start_o), 64'((k == 21) || (k == 42)));
            if (k == 21) check("clamp_shot", 64'(shot_idx_o), 64'd1);
        end
        abort();

        // Width 0 behaves as width 1
        set_cfg(20, 3, 0, 0);
        arm();
        for (int k = 1; k <= 30; k++) begin
            tick();
            check("w0_start", 64'(start_o), 64'((k == 4) || (k == 25)));
        end
        abort();

        // Config shadowing, then abort mid-pulse and re-arm
        set_cfg(30, 2, 5, 0);
        arm();
        cfg_period = 20'd5;
        for (int k = 1; k <= 65; k++) begin
            tick();
            check("shadow_start", 64'(start_o), 64'(((k % 31) >= 3) && ((k % 31) <= 7)));
        end
        abort();
        check("abort_shot_held", 64'(shot_idx_o), 64'd3);
        arm();
        for (int k = 1; k <= 3; k++) begin
            tick();
        end
        check("rearm_start", 64'(start_o), 64'd1);
        check("rearm_shot",  64'(shot_idx_o), 64'd1);

        // Asynchronous reset mid-burst, between edges
        for (int k = 0; k < 7; k++) tick();
        @(negedge clk_i);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(negedge clk_i);
        rst = 1'b1;
        en  = 1'b0;
        tick();
        check("post_rst_busy", 64'(busy_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
